// File: rtl/banner_pkg.sv
// Shared types and default geometry for the banner animator.
// The optional blink feature is selected with BANNER_BLINK_EN.
package banner_pkg;

  typedef enum logic [2:0] {
    ST_HIDDEN    = 3'd0,
    ST_SLIDE_IN  = 3'd1,
    ST_HOLD      = 3'd2,
    ST_SLIDE_OUT = 3'd3,
    ST_DONE      = 3'd4
  } banner_state_t;

  localparam int BANNER_COORD_W  = 10;
  typedef logic [BANNER_COORD_W-1:0] coord_t;

  localparam int BANNER_X_CENTER = 320;
  localparam int BANNER_Y_HIDE   = 0;
  localparam int BANNER_Y_TARGET = 50;
  localparam int BANNER_STEP     = 2;
  localparam int BANNER_SIZE     = 41;
  localparam int BANNER_WIDTH    = 80;
  localparam int BANNER_HEIGHT   = 16;
  localparam int BANNER_HOLD     = 0;
  localparam int BANNER_BLINK    = 30;
  localparam int BANNER_CNT_W    = 16;

  // Counters reach zero on the last frame of a period, so they are loaded with N-1.
  function automatic logic [BANNER_CNT_W-1:0] frames_to_load(input int frames);
    if (frames > 1) begin
      return BANNER_CNT_W'(frames - 1);
    end else begin
      return {BANNER_CNT_W{1'b0}};
    end
  endfunction

endpackage

// File: rtl/banner_animator_if.sv
// Request/status bundle between the game FSM (master) and the banner animator (slave).
interface banner_animator_if #(
  parameter int COORD_W = 10
);
  logic               show;
  logic               dismiss;
  logic [COORD_W-1:0] BannerX;
  logic [COORD_W-1:0] BannerY;
  logic [COORD_W-1:0] BannerS;
  logic [COORD_W-1:0] BannerWidth;
  logic [COORD_W-1:0] BannerHeight;
  logic               BannerVisible;
  logic [2:0]         BannerState;
  logic               BannerDone;

  modport master (
    output show, dismiss,
    input  BannerX, BannerY, BannerS, BannerWidth, BannerHeight,
    input  BannerVisible, BannerState, BannerDone
  );

  modport slave (
    input  show, dismiss,
    output BannerX, BannerY, BannerS, BannerWidth, BannerHeight,
    output BannerVisible, BannerState, BannerDone
  );
endinterface

// File: rtl/banner_frame_counter.sv
// Load/decrement frame counter with a registered zero flag; saturates at zero.
module banner_frame_counter #(
  parameter int CNT_W = 16
) (
  input  logic             frame_clk,
  input  logic             Reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             zero_q;

  // Next count: load wins over decrement.
  always_comb begin
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count and zero-flag registers.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q  <= {CNT_W{1'b0}};
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == {CNT_W{1'b0}});
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/banner_animator.sv
// Banner sprite animator: slides in, holds, slides out, reports phase.
// Optional HOLD blink enabled by defining BANNER_BLINK_EN.
module banner_animator
  import banner_pkg::*;
#(
  parameter int COORD_W      = BANNER_COORD_W,
  parameter int X_CENTER     = BANNER_X_CENTER,
  parameter int Y_HIDE       = BANNER_Y_HIDE,
  parameter int Y_TARGET     = BANNER_Y_TARGET,
  parameter int STEP         = BANNER_STEP,
  parameter int SIZE         = BANNER_SIZE,
  parameter int WIDTH        = BANNER_WIDTH,
  parameter int HEIGHT       = BANNER_HEIGHT,
  parameter int HOLD_FRAMES  = BANNER_HOLD,
  parameter int BLINK_FRAMES = BANNER_BLINK
) (
  input  logic              frame_clk,
  input  logic              Reset_n,
  banner_animator_if.slave  bus
);

  localparam int EXT_W = COORD_W + 1;
  typedef logic [EXT_W-1:0] ext_t;

  localparam ext_t HIDE_X      = ext_t'(Y_HIDE);
  localparam ext_t TARGET_X    = ext_t'(Y_TARGET);
  localparam ext_t STEP_X      = ext_t'(STEP);
  localparam ext_t HIDE_PLUS_X = ext_t'(Y_HIDE + STEP);

  localparam logic [COORD_W-1:0] Y_HIDE_C   = COORD_W'(Y_HIDE);
  localparam logic [COORD_W-1:0] Y_TARGET_C = COORD_W'(Y_TARGET);

  localparam bit                    HOLD_TO_EN = (HOLD_FRAMES > 32'sd0);
  localparam logic [BANNER_CNT_W-1:0] HOLD_LOAD = frames_to_load(HOLD_FRAMES);

  if (STEP < 32'sd1) begin : g_bad_step
    $error("banner_animator: STEP must be positive");
  end
  if (Y_HIDE >= Y_TARGET) begin : g_bad_rows
    $error("banner_animator: Y_HIDE must be below Y_TARGET");
  end
  if (BLINK_FRAMES < 32'sd1) begin : g_bad_blink
    $error("banner_animator: BLINK_FRAMES must be positive");
  end

  banner_state_t      state_q;
  logic [COORD_W-1:0] y_q;
  logic               vis_q;
  logic               done_q;

  ext_t y_ext_s;
  ext_t y_up_s;
  ext_t y_dn_s;
  logic arrive_s;
  logic depart_s;
  logic hold_load_s;
  logic hold_dec_s;
  logic hold_zero_s;
  logic hold_timeout_s;
  logic blink_vis_s;

  // Widened arithmetic so targets near the top of the range never wrap.
  always_comb begin
    y_ext_s        = {1'b0, y_q};
    y_up_s         = y_ext_s + STEP_X;
    y_dn_s         = y_ext_s - STEP_X;
    arrive_s       = (y_up_s >= TARGET_X);
    depart_s       = (y_ext_s <= HIDE_PLUS_X);
    hold_load_s    = (state_q == ST_SLIDE_IN) && !bus.dismiss && arrive_s;
    hold_dec_s     = (state_q == ST_HOLD);
    hold_timeout_s = HOLD_TO_EN && (state_q == ST_HOLD) && hold_zero_s;
  end

  banner_frame_counter #(
    .CNT_W (BANNER_CNT_W)
  ) u_hold_cnt (
    .frame_clk  (frame_clk),
    .Reset_n    (Reset_n),
    .load_i     (hold_load_s),
    .load_val_i (HOLD_LOAD),
    .dec_i      (hold_dec_s),
    .zero_o     (hold_zero_s)
  );

`ifdef BANNER_BLINK_EN
  localparam logic [BANNER_CNT_W-1:0] BLINK_LOAD = frames_to_load(BLINK_FRAMES);

  logic blink_load_s;
  logic blink_zero_s;

  // The blink period restarts on HOLD entry and on every toggle.
  always_comb begin
    blink_load_s = hold_load_s || ((state_q == ST_HOLD) && blink_zero_s);
    blink_vis_s  = blink_zero_s ? ~vis_q : vis_q;
  end

  banner_frame_counter #(
    .CNT_W (BANNER_CNT_W)
  ) u_blink_cnt (
    .frame_clk  (frame_clk),
    .Reset_n    (Reset_n),
    .load_i     (blink_load_s),
    .load_val_i (BLINK_LOAD),
    .dec_i      (hold_dec_s),
    .zero_o     (blink_zero_s)
  );
`else
  assign blink_vis_s = 1'b1;
`endif

  // Banner phase FSM with registered position, visibility and done flag.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_HIDDEN;
      y_q     <= Y_HIDE_C;
      vis_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_HIDDEN: begin
          if (bus.show) begin
            state_q <= ST_SLIDE_IN;
            vis_q   <= 1'b1;
          end
        end
        ST_SLIDE_IN: begin
          vis_q <= 1'b1;
          if (bus.dismiss) begin
            state_q <= ST_SLIDE_OUT;
          end else if (arrive_s) begin
            state_q <= ST_HOLD;
            y_q     <= Y_TARGET_C;
          end else begin
            y_q <= y_up_s[COORD_W-1:0];
          end
        end
        ST_HOLD: begin
          if (bus.dismiss || hold_timeout_s) begin
            state_q <= ST_SLIDE_OUT;
            vis_q   <= 1'b1;
          end else begin
            vis_q <= blink_vis_s;
          end
        end
        ST_SLIDE_OUT: begin
          vis_q <= 1'b1;
          if (depart_s) begin
            state_q <= ST_DONE;
            y_q     <= Y_HIDE_C;
            vis_q   <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            y_q <= y_dn_s[COORD_W-1:0];
          end
        end
        ST_DONE: begin
          if (!bus.show) begin
            state_q <= ST_HIDDEN;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_HIDDEN;
          y_q     <= Y_HIDE_C;
          vis_q   <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.BannerX       = COORD_W'(X_CENTER);
  assign bus.BannerS       = COORD_W'(SIZE);
  assign bus.BannerWidth   = COORD_W'(WIDTH);
  assign bus.BannerHeight  = COORD_W'(HEIGHT);
  assign bus.BannerY       = y_q;
  assign bus.BannerVisible = vis_q;
  assign bus.BannerState   = state_q;
  assign bus.BannerDone    = done_q;

endmodule

// File: tb/tb_banner_animator.sv
// Directed bench: default banner via a vector table, plus STEP=3/timeout and async-reset sequences.
module tb_banner_animator;
  import banner_pkg::*;

  logic frame_clk = 1'b0;
  logic Reset_n   = 1'b0;
  int   checks    = 0;
  int   errors    = 0;

  always #5 frame_clk = ~frame_clk;

  banner_animator_if #(.COORD_W(10)) bus_a ();
  banner_animator_if #(.COORD_W(10)) bus_b ();

  banner_animator dut_a (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (bus_a)
  );

  banner_animator #(
    .STEP         (3),
    .HOLD_FRAMES  (5),
    .BLINK_FRAMES (2)
  ) dut_b (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (bus_b)
  );

  typedef struct {
    logic       show;
    logic       dismiss;
    logic [2:0] st;
    logic [9:0] y;
    logic       vis;
    logic       done;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic d, input int st, input int y,
                     input logic v, input logic dn);
    vec_t r;
    r.show = s; r.dismiss = d; r.st = 3'(st); r.y = 10'(y); r.vis = v; r.done = dn;
    tbl.push_back(r);
  endtask

  task automatic chk_a(input string tag, input int idx, input int st, input int y,
                       input int v, input int dn);
    chk({tag, "_state"}, idx, int'(bus_a.BannerState), st);
    chk({tag, "_y"}, idx, int'(bus_a.BannerY), y);
    chk({tag, "_vis"}, idx, int'(bus_a.BannerVisible), v);
    chk({tag, "_done"}, idx, int'(bus_a.BannerDone), dn);
  endtask

  task automatic step_a(input logic s, input logic d);
    @(negedge frame_clk);
    bus_a.show    = s;
    bus_a.dismiss = d;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic step_b(input logic s, input logic d);
    @(negedge frame_clk);
    bus_b.show    = s;
    bus_b.dismiss = d;
    @(posedge frame_clk);
    #1;
  endtask

  logic blink_exp [4];

  initial begin
    bus_a.show = 1'b0; bus_a.dismiss = 1'b0;
    bus_b.show = 1'b0; bus_b.dismiss = 1'b0;
`ifdef BANNER_BLINK_EN
    blink_exp = '{1'b1, 1'b0, 1'b0, 1'b1};
`else
    blink_exp = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    // Default instance: full show/hold/dismiss cycle, then an early dismiss at Y=20.
    add(1'b1, 1'b0, 1, 0, 1'b1, 1'b0);
    for (int k = 1; k <= 24; k++) add(1'b1, 1'b0, 1, 2 * k, 1'b1, 1'b0);
    add(1'b1, 1'b0, 2, 50, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 2, 50, 1'b1, 1'b0);
    add(1'b1, 1'b1, 3, 50, 1'b1, 1'b0);
    for (int k = 1; k <= 24; k++) add(1'b1, 1'b0, 3, 50 - 2 * k, 1'b1, 1'b0);
    add(1'b1, 1'b0, 4, 0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 4, 0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1, 0, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) add(1'b1, 1'b0, 1, 2 * k, 1'b1, 1'b0);
    add(1'b1, 1'b1, 3, 20, 1'b1, 1'b0);
    for (int k = 1; k <= 9; k++) add(1'b0, (k == 3), 3, 20 - 2 * k, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4, 0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    // Reset state and constant geometry, checked before any clock edge.
    #1;
    chk_a("reset", 0, 0, 0, 0, 0);
    chk("x_const", 0, int'(bus_a.BannerX), 320);
    chk("s_const", 0, int'(bus_a.BannerS), 41);
    chk("w_const", 0, int'(bus_a.BannerWidth), 80);
    chk("h_const", 0, int'(bus_a.BannerHeight), 16);
    repeat (2) @(negedge frame_clk);
    Reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step_a(tbl[i].show, tbl[i].dismiss);
      chk_a("tbl", i, int'(tbl[i].st), int'(tbl[i].y), int'(tbl[i].vis), int'(tbl[i].done));
    end

    // STEP=3 clamps at 50 on the 17th edge, then the 5-frame hold timeout fires.
    step_b(1'b1, 1'b0);
    chk("b_enter", 0, int'(bus_b.BannerState), 1);
    for (int k = 1; k <= 16; k++) begin
      step_b(1'b1, 1'b0);
      chk("b_slide_y", k, int'(bus_b.BannerY), 3 * k);
    end
    step_b(1'b1, 1'b0);
    chk("b_clamp_y", 17, int'(bus_b.BannerY), 50);
    chk("b_hold", 17, int'(bus_b.BannerState), 2);
    chk("b_hold_vis", 0, int'(bus_b.BannerVisible), 1);
    for (int k = 1; k <= 4; k++) begin
      step_b(1'b1, 1'b0);
      chk("b_hold_st", k, int'(bus_b.BannerState), 2);
      chk("b_blink_vis", k, int'(bus_b.BannerVisible), int'(blink_exp[k-1]));
    end
    step_b(1'b1, 1'b0);
    chk("b_timeout", 5, int'(bus_b.BannerState), 3);
    chk("b_out_y", 5, int'(bus_b.BannerY), 50);
    chk("b_out_vis", 5, int'(bus_b.BannerVisible), 1);
    step_b(1'b0, 1'b0);
    chk("b_out_step", 6, int'(bus_b.BannerY), 47);

    // Asynchronous reset mid slide-out at Y=30, show held through release.
    step_a(1'b1, 1'b0);
    for (int k = 0; k < 25; k++) step_a(1'b1, 1'b0);
    chk("r_hold", 0, int'(bus_a.BannerState), 2);
    step_a(1'b1, 1'b1);
    for (int k = 0; k < 10; k++) step_a(1'b1, 1'b0);
    chk_a("r_pre", 0, 3, 30, 1, 0);
    @(negedge frame_clk);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_a("r_async", 0, 0, 0, 0, 0);
    chk("r_x_const", 0, int'(bus_a.BannerX), 320);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    @(posedge frame_clk);
    #1;
    chk_a("r_release", 0, 1, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
